// File: rtl/spi_response_framer_pkg.sv
// Shared types and constants for the SPI response framer: serializer states, frame layout
// and the per-pair FIFO entry.
package spi_response_framer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StTag  = 3'd2,
    StB0   = 3'd3,
    StB1   = 3'd4,
    StCsum = 3'd5
  } frame_state_e;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN      = 5;
  localparam int unsigned TAG_W          = 3;
  localparam int unsigned ENTRY_W        = TAG_W + 16;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [7:0]       b0;
    logic [7:0]       b1;
  } pair_entry_t;

  function automatic logic [7:0] frame_checksum(logic [7:0] hdr, pair_entry_t e);
    return hdr ^ {5'b0, e.tag} ^ e.b0 ^ e.b1;
  endfunction

endpackage

// File: rtl/resp_pair_fifo.sv
// Synchronous FIFO of response pairs; an extra pointer MSB separates full from empty.
module resp_pair_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 19
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth) + 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  fill;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);

  // A pop on the same edge frees the slot being written, so a full FIFO still takes the push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign rdata = mem_q[rd_ptr_q[PtrW-2:0]];
  assign fill  = wr_ptr_q - rd_ptr_q;
  assign count = CntW'(fill);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PtrW-2:0]] <= wdata;
  end

endmodule

// File: rtl/spi_response_framer.sv
// Pairs decoded response bytes with their command tag, queues them and emits each pair as
// a 5-byte checksummed frame on a valid/ready byte stream.
module spi_response_framer
  import spi_response_framer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      in_byte,
  input  logic                            in_valid,
  input  logic [2:0]                      in_tag,
  output logic [7:0]                      out_byte,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending
);

  logic         idx_q;
  logic [7:0]   b0_q;
  logic [2:0]   tag_q;
  logic         overflow_q;
  logic         push, pop;
  logic         fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] fifo_rdata;
  pair_entry_t  entry;
  pair_entry_t  frame_q;
  frame_state_e state_q, state_d;

  assign entry    = '{tag: tag_q, b0: b0_q, b1: in_byte};
  assign push     = in_valid && idx_q && (!fifo_full || pop);
  assign overflow = overflow_q;

  // Assembler runs regardless of serializer state; a dropped pair still realigns idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= 1'b0;
      b0_q       <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else if (in_valid) begin
      if (!idx_q) begin
        b0_q  <= in_byte;
        tag_q <= in_tag;
        idx_q <= 1'b1;
      end else begin
        idx_q <= 1'b0;
        if (!push) overflow_q <= 1'b1;
      end
    end
  end

  resp_pair_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (pending)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) frame_q <= pair_entry_t'(fifo_rdata);
    end
  end

  // out_valid is high in every non-idle state, so out_ready alone marks acceptance there.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StHdr;
        end
      end
      StHdr:  if (out_ready) state_d = StTag;
      StTag:  if (out_ready) state_d = StB0;
      StB0:   if (out_ready) state_d = StB1;
      StB1:   if (out_ready) state_d = StCsum;
      StCsum: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StHdr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = (state_q != StIdle);
    out_byte  = 8'h00;
    unique case (state_q)
      StIdle:  out_byte = 8'h00;
      StHdr:   out_byte = HEADER;
      StTag:   out_byte = {5'b0, frame_q.tag};
      StB0:    out_byte = frame_q.b0;
      StB1:    out_byte = frame_q.b1;
      StCsum:  out_byte = frame_checksum(HEADER, frame_q);
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spi_response_framer.sv
// Self-checking bench for spi_response_framer: directed scenarios plus a randomized stream
// checked against a frame-level reference model.
module tb_spi_response_framer;
  import spi_response_framer_pkg::*;

  localparam int unsigned Depth = 4;
  localparam logic [7:0]  Hdr   = 8'hA5;
  localparam int          Flen  = int'(FRAME_LEN);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic [2:0] in_tag = 3'd0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;
  logic [2:0] pending;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  spi_response_framer #(
    .FIFO_DEPTH (Depth),
    .HEADER     (Hdr)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .pending   (pending)
  );

  // Record every byte the sink accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_byte);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got %0d bytes required completion", got.size());
    $fatal(1, "timeout");
  end

  // Byte k of the frame carrying (t, a, b).
  function automatic logic [7:0] frame_byte(logic [2:0] t, logic [7:0] a, logic [7:0] b, int k);
    case (k)
      0:       return Hdr;
      1:       return {5'b0, t};
      2:       return a;
      3:       return b;
      default: return Hdr ^ {5'b0, t} ^ a ^ b;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_pair(input logic [2:0] t, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_tag = t;
    in_byte = a;
    tick();
    in_tag = 3'($urandom);
    in_byte = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int c = 0;
    while (got.size() < n && c < limit) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", out_byte); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single;
    int base = got.size();
    out_ready = 1'b1;
    send_pair(3'd2, 8'h12, 8'h34);
    n_cmp++; if (pending !== 3'd1) begin n_fail++; $display("FAIL single_pending got %0d want 1", pending); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_byte !== Hdr) begin
      n_fail++; $display("FAIL single_latency got %b/%h want 1/%h", out_valid, out_byte, Hdr);
    end
    wait_bytes(base + Flen, 20);
    tick();
    n_cmp++;
    if (got.size() != base + Flen) begin
      n_fail++; $display("FAIL single_count got %0d want %0d", got.size() - base, Flen);
    end
    for (int k = 0; k < Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(3'd2, 8'h12, 8'h34, k)) begin
        n_fail++; $display("FAIL single_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(3'd2, 8'h12, 8'h34, k));
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow got %b want 0", overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int base = got.size();
    logic pv, pr;
    logic [7:0] pb;
    out_ready = 1'b0;
    send_pair(3'd2, 8'h12, 8'h34);
    for (int i = 0; i < 30; i++) begin
      out_ready = !out_ready;
      pv = out_valid;
      pb = out_byte;
      pr = out_ready;
      tick();
      if (pv && !pr) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_byte !== pb) begin
          n_fail++; $display("FAIL bp_hold got %b/%h want 1/%h", out_valid, out_byte, pb);
        end
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != base + Flen) begin
      n_fail++; $display("FAIL bp_count got %0d want %0d", got.size() - base, Flen);
    end
    for (int k = 0; k < Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(3'd2, 8'h12, 8'h34, k)) begin
        n_fail++; $display("FAIL bp_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(3'd2, 8'h12, 8'h34, k));
      end
    end
  endtask

  task automatic test_overflow;
    int base = got.size();
    logic [2:0] t [6];
    logic [7:0] a [6];
    logic [7:0] b [6];
    out_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      t[p] = 3'($urandom); a[p] = 8'($urandom); b[p] = 8'($urandom);
      send_pair(t[p], a[p], b[p]);
    end
    tick();
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL ovf_pending got %0d want 4", pending); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    out_ready = 1'b1;
    wait_bytes(base + 5 * Flen, 80);
    repeat (3) tick();
    n_cmp++;
    if (got.size() != base + 5 * Flen) begin
      n_fail++; $display("FAIL ovf_count got %0d want %0d", got.size() - base, 5 * Flen);
    end
    for (int k = 0; k < 5 * Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen)) begin
        n_fail++; $display("FAIL ovf_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen));
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    out_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_full_simul;
    int base = got.size();
    logic [2:0] t [6];
    logic [7:0] a [6];
    logic [7:0] b [6];
    for (int p = 0; p < 6; p++) begin
      t[p] = 3'($urandom); a[p] = 8'($urandom); b[p] = 8'($urandom);
    end
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) send_pair(t[p], a[p], b[p]);
    tick();
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL fs_full got %0d want 4", pending); end
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_byte !== frame_byte(t[0], a[0], b[0], 4)) begin
      n_fail++; $display("FAIL fs_csum got %h want %h", out_byte, frame_byte(t[0], a[0], b[0], 4));
    end
    in_valid = 1'b1; in_tag = t[5]; in_byte = a[5];
    tick();
    in_byte = b[5]; in_tag = 3'($urandom); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL fs_pending got %0d want 4", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fs_overflow got %b want 0", overflow); end
    n_cmp++;
    if (out_valid !== 1'b1 || out_byte !== Hdr) begin
      n_fail++; $display("FAIL fs_next_hdr got %b/%h want 1/%h", out_valid, out_byte, Hdr);
    end
    out_ready = 1'b1;
    wait_bytes(base + 6 * Flen, 80);
    repeat (2) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != base + 6 * Flen) begin
      n_fail++; $display("FAIL fs_count got %0d want %0d", got.size() - base, 6 * Flen);
    end
    for (int k = 0; k < 6 * Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen)) begin
        n_fail++; $display("FAIL fs_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen));
      end
    end
  endtask

  task automatic test_back_to_back;
    int base = got.size();
    logic [2:0] t [3];
    logic [7:0] a [3];
    logic [7:0] b [3];
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      t[p] = 3'($urandom); a[p] = 8'($urandom); b[p] = 8'($urandom);
      send_pair(t[p], a[p], b[p]);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3 * Flen; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble%0d got %b want 1", i, out_valid); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", out_valid); end
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != base + 3 * Flen) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", got.size() - base, 3 * Flen);
    end
    for (int k = 0; k < 3 * Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen)) begin
        n_fail++; $display("FAIL b2b_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen));
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] a0, b0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    out_ready = 1'b0;
    send_pair(3'd1, a0, b0);
    for (int p = 0; p < 5; p++) send_pair(3'($urandom), 8'($urandom), 8'($urandom));
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_byte !== a0) begin n_fail++; $display("FAIL rm_in_b0 got %h want %h", out_byte, a0); end
    in_valid = 1'b1; in_tag = 3'd3; in_byte = 8'($urandom);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b want 0", out_valid); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rm_pending got %0d want 0", pending); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_overflow got %b want 0", overflow); end
    n_cmp++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL rm_byte got %h want 00", out_byte); end
    rst_n = 1'b1;
    base = got.size();
    out_ready = 1'b1;
    send_pair(3'd7, 8'hFF, 8'h00);
    wait_bytes(base + Flen, 20);
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != base + Flen) begin
      n_fail++; $display("FAIL rm_count got %0d want %0d", got.size() - base, Flen);
    end
    for (int k = 0; k < Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(3'd7, 8'hFF, 8'h00, k)) begin
        n_fail++; $display("FAIL rm_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(3'd7, 8'hFF, 8'h00, k));
      end
    end
  endtask

  // Random traffic kept below capacity, so every pair must come out exactly once, in order.
  task automatic test_random;
    int base = got.size();
    int np = 40;
    int c;
    logic [2:0] t [40];
    logic [7:0] a [40];
    logic [7:0] b [40];
    for (int p = 0; p < np; p++) begin
      t[p] = 3'($urandom); a[p] = 8'($urandom); b[p] = 8'($urandom);
      c = 0;
      while ((p - (got.size() - base) / Flen) >= int'(Depth) && c < 200) begin
        out_ready = ($urandom_range(0, 9) < 7);
        tick();
        c++;
      end
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 9) < 7);
        tick();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      send_pair(t[p], a[p], b[p]);
    end
    out_ready = 1'b1;
    wait_bytes(base + np * Flen, 600);
    repeat (2) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != base + np * Flen) begin
      n_fail++; $display("FAIL rnd_count got %0d want %0d", got.size() - base, np * Flen);
    end
    for (int k = 0; k < np * Flen && base + k < got.size(); k++) begin
      n_cmp++;
      if (got[base+k] !== frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen)) begin
        n_fail++; $display("FAIL rnd_byte%0d got %h want %h", k, got[base+k],
                           frame_byte(t[k/Flen], a[k/Flen], b[k/Flen], k % Flen));
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_simul();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
